// File: rtl/pointwise_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// pointwise_ctrl_pkg: shared types and constants for the affine controller
// Rev 1.0
// ==========================================================================
package pointwise_ctrl_pkg;

  localparam int CTRL_W_DEFAULT = 16;
  localparam int NDIM           = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  function automatic longint total_iters(input longint e0, input longint e1, input longint e2);
    return e0 * e1 * e2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pointwise_loop_counter.sv
`default_nettype none
// ==========================================================================
// pointwise_loop_counter: one wrapping loop index with terminal-count flag
// Rev 1.0
// ==========================================================================
module pointwise_loop_counter
  import pointwise_ctrl_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [CTRL_W:0]   extent,
  output logic [CTRL_W-1:0] idx,
  output logic              last
);

  // Extent carries one extra bit so that a full 2^CTRL_W range is expressible
  assign last = ({1'b0, idx} == (extent - 1'b1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= last ? '0 : idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pointwise_affine_ctrl.sv
`default_nettype none
// ==========================================================================
// pointwise_affine_ctrl: 3-deep affine loop-nest write controller (wen/ctrl_vars)
// Rev 1.0
// ==========================================================================
module pointwise_affine_ctrl
  import pointwise_ctrl_pkg::*;
#(
  parameter int CTRL_W      = CTRL_W_DEFAULT,
  parameter int EXT0        = 1,
  parameter int EXT1        = 64,
  parameter int EXT2        = 64,
  parameter int II          = 1,
  parameter int START_DELAY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              en,
  output logic              wen,
  output logic [CTRL_W-1:0] ctrl_vars [NDIM-1:0],
  output logic              done
);

  localparam int            DLY_W   = 16;
  localparam longint        MAX_EXT = longint'(1) << CTRL_W;
  localparam logic [DLY_W-1:0] SD_M1 = DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [7:0]    II_M1   = 8'(II - 1);

  if (EXT0 < 1 || longint'(EXT0) > MAX_EXT || EXT1 < 1 || longint'(EXT1) > MAX_EXT ||
      EXT2 < 1 || longint'(EXT2) > MAX_EXT || II < 1 || II > 255 ||
      START_DELAY < 0 || START_DELAY > 65535) begin : g_param_check
    $error("pointwise_affine_ctrl: parameter out of range");
  end

  ctrl_state_t       state, state_n;
  logic [DLY_W-1:0]  delay_cnt, delay_n;
  logic [7:0]        ii_cnt, ii_n;
  logic              wen_n, done_n, issue, last_iter;
  logic [CTRL_W-1:0] idx    [NDIM-1:0];
  logic [CTRL_W-1:0] vars_n [NDIM-1:0];
  logic              inc_v  [NDIM-1:0];
  logic              last_v [NDIM-1:0];

  assign issue     = (state == RUN) && en && !flush && (ii_cnt == '0);
  // Carry out of the outermost counter means every dimension is at its last value
  assign last_iter = inc_v[0] & last_v[0];

  for (genvar d = 0; d < NDIM; d++) begin : g_dim
    localparam int              E     = (d == 0) ? EXT0 : (d == 1) ? EXT1 : EXT2;
    localparam logic [CTRL_W:0] EXT_L = (CTRL_W + 1)'(E);

    if (d == NDIM - 1) begin : g_inner
      assign inc_v[d] = issue;
    end else begin : g_outer
      assign inc_v[d] = inc_v[d+1] & last_v[d+1];
    end

    pointwise_loop_counter #(.CTRL_W(CTRL_W)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (flush),
      .inc    (inc_v[d]),
      .extent (EXT_L),
      .idx    (idx[d]),
      .last   (last_v[d])
    );
  end

  always_comb begin
    state_n = state;
    delay_n = delay_cnt;
    ii_n    = ii_cnt;
    wen_n   = 1'b0;
    done_n  = done;
    vars_n  = ctrl_vars;
    if (flush) begin
      state_n = (START_DELAY == 0) ? RUN : DELAY;
      delay_n = '0;
      ii_n    = '0;
      done_n  = 1'b0;
    end else begin
      case (state)
        IDLE: done_n = 1'b0;
        DELAY: begin
          delay_n = delay_cnt + 1'b1;
          if (delay_cnt == SD_M1) state_n = RUN;
        end
        RUN: begin
          if (en) begin
            ii_n = (ii_cnt == II_M1) ? '0 : ii_cnt + 1'b1;
            if (issue) begin
              wen_n  = 1'b1;
              vars_n = idx;
              if (last_iter) state_n = DONE;
            end
          end
        end
        DONE: done_n = 1'b1;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      delay_cnt <= '0;
      ii_cnt    <= '0;
      wen       <= 1'b0;
      done      <= 1'b0;
      ctrl_vars <= '{default: '0};
    end else begin
      state     <= state_n;
      delay_cnt <= delay_n;
      ii_cnt    <= ii_n;
      wen       <= wen_n;
      done      <= done_n;
      ctrl_vars <= vars_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pointwise_affine_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_pointwise_affine_ctrl: scoreboard bench, two controller configurations
// Rev 1.0
// ==========================================================================
module tb_pointwise_affine_ctrl;
  import pointwise_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic en    = 1'b1;
  int   vecs  = 0;
  int   errs  = 0;

  always #5 clk = ~clk;

  typedef struct {
    int v0;
    int v1;
    int v2;
  } exp_t;

  for (genvar c = 0; c < 2; c++) begin : g_cfg
    localparam int E0    = (c == 0) ? 1 : 2;
    localparam int E1    = (c == 0) ? 4 : 1;
    localparam int E2    = (c == 0) ? 4 : 3;
    localparam int IIV   = (c == 0) ? 2 : 1;
    localparam int SD    = (c == 0) ? 3 : 0;
    localparam int TOTAL = int'(total_iters(E0, E1, E2));

    logic        wen;
    logic        done;
    logic [15:0] cv [2:0];

    pointwise_affine_ctrl #(
      .CTRL_W(16), .EXT0(E0), .EXT1(E1), .EXT2(E2), .II(IIV), .START_DELAY(SD)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .en        (en),
      .wen       (wen),
      .ctrl_vars (cv),
      .done      (done)
    );

    // Reference: iteration number k is decoded into the loop tuple arithmetically
    exp_t        sb [$];
    ctrl_state_t st     = IDLE;
    int          k      = 0;
    int          ph     = 0;
    int          wait_n = 0;
    int          pcnt   = 0;
    int          mv [3] = '{0, 0, 0};
    bit          m_done = 1'b0;
    bit          done_q = 1'b0;

    always @(posedge clk) begin
      exp_t e;
      if (!rst_n) begin
        st     = IDLE;
        m_done = 1'b0;
        mv     = '{0, 0, 0};
        pcnt   = 0;
      end else if (flush) begin
        k      = 0;
        ph     = 0;
        m_done = 1'b0;
        wait_n = SD;
        pcnt   = 0;
        st     = (SD == 0) ? RUN : DELAY;
      end else begin
        case (st)
          DELAY: begin
            wait_n--;
            if (wait_n == 0) st = RUN;
          end
          RUN: if (en) begin
            if (ph == 0) begin
              e.v0 = k / (E1 * E2);
              e.v1 = (k / E2) % E1;
              e.v2 = k % E2;
              sb.push_back(e);
              mv = '{e.v0, e.v1, e.v2};
              k++;
              if (k == TOTAL) st = DONE;
            end
            ph = (ph + 1) % IIV;
          end
          DONE: m_done = 1'b1;
          default: ;
        endcase
      end
    end

    always @(negedge clk) begin
      exp_t e;
      bit   exp_w;
      int   want [3];
      exp_w = (sb.size() != 0);
      want  = mv;
      if (exp_w) begin
        e    = sb.pop_front();
        want = '{e.v0, e.v1, e.v2};
      end
      vecs++;
      if (wen !== exp_w) begin
        errs++;
        $display("FAIL cfg%0d wen @%0t: got %b want %b", c, $time, wen, exp_w);
      end
      for (int d = 0; d < 3; d++) begin
        vecs++;
        if (cv[d] !== 16'(want[d])) begin
          errs++;
          $display("FAIL cfg%0d ctrl_vars[%0d] @%0t: got %0d want %0d", c, d, $time, cv[d], want[d]);
        end
      end
      vecs++;
      if (done !== m_done) begin
        errs++;
        $display("FAIL cfg%0d done @%0t: got %b want %b", c, $time, done, m_done);
      end
      if (wen === 1'b1) pcnt++;
      if (done === 1'b1 && !done_q) begin
        vecs++;
        if (pcnt != TOTAL) begin
          errs++;
          $display("FAIL cfg%0d pulse_count @%0t: got %0d want %0d", c, $time, pcnt, TOTAL);
        end
      end
      done_q = (done === 1'b1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(3);
    // full run, en held high
    pulse_flush();
    step(45);
    // stall window inside RUN
    pulse_flush();
    step(7);
    en = 1'b0;
    step(5);
    en = 1'b1;
    step(45);
    // restart mid-RUN after a few pulses
    pulse_flush();
    step(11);
    pulse_flush();
    step(45);
    // reset wins over a simultaneous flush
    pulse_flush();
    step(10);
    rst_n = 1'b0;
    flush = 1'b1;
    step(1);
    rst_n = 1'b1;
    flush = 1'b0;
    step(10);
    // flush from DONE with en low: delay still counts, RUN waits for en
    pulse_flush();
    step(45);
    en = 1'b0;
    pulse_flush();
    step(8);
    en = 1'b1;
    step(45);
    // randomized en / flush / reset traffic
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step(1);
    end
    en    = 1'b1;
    rst_n = 1'b1;
    pulse_flush();
    step(50);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
